right_shift_seq: RTL and testbench

//  Multi-cycle right shifter for the RV32 ALU: SRL/SRLI (logical) and SRA/SRAI (arithmetic).

---
 rtl/right_shift_seq_pkg.sv | 20 ++
 rtl/right_shift_step.sv | 17 +
 rtl/right_shift_seq.sv | 100 ++++++++++
 tb/tb_right_shift_seq.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/right_shift_seq_pkg.sv
// Shared widths, shift-op encodings and FSM states for the multi-cycle right shifter.
package right_shift_seq_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned SHAMT_W = 5;
    // Wide enough to hold any per-cycle shift amount up to XLEN.
    localparam int unsigned K_W     = $clog2(XLEN + 1);

    // funct7 bit 5 distinguishes SRA/SRAI (1) from SRL/SRLI (0).
    localparam int unsigned FUNCT7_ARITH_BIT = 5;
    localparam logic        OP_SRL = 1'b0;
    localparam logic        OP_SRA = 1'b1;

    typedef enum logic [1:0] {
        RS_IDLE  = 2'd0,
        RS_SHIFT = 2'd1,
        RS_DONE  = 2'd2
    } rs_state_e;

endpackage

// File: rtl/right_shift_step.sv
// One combinational shift step: data >> k, vacated bits filled with fill.
module right_shift_step
    import right_shift_seq_pkg::*;
(
    input  logic [XLEN-1:0] data,
    input  logic [K_W-1:0]  k,
    input  logic            fill,
    output logic [XLEN-1:0] y
);

    logic signed [XLEN:0] ext;

    // Prepending the fill bit lets a single arithmetic shift cover both SRL and SRA.
    assign ext = {fill, data};
    assign y   = XLEN'(ext >>> k);

endmodule

// File: rtl/right_shift_seq.sv
// Multi-cycle RV32 right shifter (SRL/SRA), at most STEP bits per cycle, valid/ready on both sides.
module right_shift_seq
    import right_shift_seq_pkg::*;
#(
    parameter int unsigned STEP = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    in_a,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic               in_arith,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_y
);

    rs_state_e          state, state_nxt;
    logic [XLEN-1:0]    data, data_nxt;
    logic [SHAMT_W-1:0] cnt, cnt_nxt;
    logic               fill, fill_nxt;
    logic [K_W-1:0]     k;
    logic [XLEN-1:0]    step_y;

    // Bits to shift this cycle: a full STEP, or whatever remains.
    assign k = (K_W'(cnt) >= K_W'(STEP)) ? K_W'(STEP) : K_W'(cnt);

    right_shift_step u_step (
        .data (data),
        .k    (k),
        .fill (fill),
        .y    (step_y)
    );

    assign in_ready  = (state == RS_IDLE);
    assign out_valid = (state == RS_DONE);
    assign out_y     = data;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RS_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data <= '0;
            cnt  <= '0;
            fill <= 1'b0;
        end else begin
            data <= data_nxt;
            cnt  <= cnt_nxt;
            fill <= fill_nxt;
        end
    end

    // Next-state and datapath update; flush aborts without touching data/cnt.
    always_comb begin
        state_nxt = state;
        data_nxt  = data;
        cnt_nxt   = cnt;
        fill_nxt  = fill;
        if (flush) begin
            state_nxt = RS_IDLE;
        end else begin
            case (state)
                RS_IDLE: begin
                    if (in_valid) begin
                        data_nxt  = in_a;
                        cnt_nxt   = in_shamt;
                        fill_nxt  = in_arith & in_a[XLEN-1];
                        state_nxt = (in_shamt == '0) ? RS_DONE : RS_SHIFT;
                    end
                end
                RS_SHIFT: begin
                    data_nxt = step_y;
                    cnt_nxt  = cnt - SHAMT_W'(k);
                    if (cnt == SHAMT_W'(k)) begin
                        state_nxt = RS_DONE;
                    end
                end
                RS_DONE: begin
                    if (out_ready) begin
                        state_nxt = RS_IDLE;
                    end
                end
                default: begin
                    state_nxt = RS_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_right_shift_seq.sv
// Bench for right_shift_seq: directed literal cases plus randomized traffic against a behavioural model.
module tb_right_shift_seq;

    localparam int unsigned STEP = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [4:0]  in_shamt;
    logic        in_arith;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_y;

    int n_checks = 0;
    int n_pass   = 0;

    right_shift_seq #(.STEP(STEP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_shamt  (in_shamt),
        .in_arith  (in_arith),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] fshift(input logic [31:0] a, input int n, input logic ar);
        if (ar) return 32'($signed(a) >>> n);
        return a >> n;
    endfunction

    // Model: the register always holds the accepted operand shifted by the bits done so far.
    logic        m_seen = 1'b0;
    logic        m_busy, m_valid, m_arith;
    logic [31:0] m_a;
    int          m_sh, m_target;
    int          n_xfer = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_seen   <= 1'b1;
            m_busy   <= 1'b0;
            m_valid  <= 1'b0;
            m_a      <= '0;
            m_arith  <= 1'b0;
            m_sh     <= 0;
            m_target <= 0;
        end else if (flush) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy   <= 1'b1;
                m_a      <= in_a;
                m_arith  <= in_arith;
                m_sh     <= 0;
                m_target <= int'(in_shamt);
                m_valid  <= (in_shamt == 5'd0);
            end
        end else if (!m_valid) begin
            m_sh    <= (m_sh + int'(STEP) > m_target) ? m_target : m_sh + int'(STEP);
            m_valid <= (m_sh + int'(STEP) >= m_target);
        end else if (out_ready) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            n_xfer  <= n_xfer + 1;
        end
    end

    // Compare DUT against the model every cycle once reset has been seen.
    always @(negedge clk) begin
        if (m_seen) begin
            check("in_ready",  32'(in_ready),  32'(!m_busy));
            check("out_valid", 32'(out_valid), 32'(m_valid));
            check("out_y",     out_y,          fshift(m_a, m_sh, m_arith));
        end
    end

    task automatic accept(input logic [31:0] a, input logic [4:0] s, input logic ar);
        int guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check("accept_timeout", 32'(0), 32'(1));
        in_valid = 1'b1;
        in_a     = a;
        in_shamt = s;
        in_arith = ar;
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = $urandom;
        in_shamt = 5'($urandom);
        in_arith = 1'($urandom);
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 200) check("valid_timeout", 32'(0), 32'(1));
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int          lat;
        logic [31:0] held;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
        in_a = '0; in_shamt = '0; in_arith = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready",  32'(in_ready),  32'(1));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_y",     out_y,          32'h0000_0000);
        rst_n = 1'b1;

        accept(32'h8000_0000, 5'd31, 1'b1);
        wait_valid(lat);
        check("sra31_y",   out_y,     32'hFFFF_FFFF);
        check("sra31_lat", 32'(lat),  32'd9);
        drain();

        accept(32'hF000_000F, 5'd4, 1'b0);
        wait_valid(lat);
        check("srl4_y",   out_y,    32'h0F00_0000);
        check("srl4_lat", 32'(lat), 32'd2);
        drain();

        accept(32'hF000_000F, 5'd4, 1'b1);
        wait_valid(lat);
        check("sra4_y", out_y, 32'hFF00_0000);
        drain();

        accept(32'h1234_5678, 5'd0, 1'b1);
        wait_valid(lat);
        check("sh0_y",     out_y,          32'h1234_5678);
        check("sh0_lat",   32'(lat),       32'd1);
        check("sh0_ready", 32'(in_ready),  32'(0));
        held = out_y;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 32'(1));
            check("bp_y",     out_y,          held);
            check("bp_ready", 32'(in_ready),  32'(0));
        end
        drain();
        check("bp_released", 32'(out_valid), 32'(0));

        accept(32'hABCD_1234, 5'd20, 1'b0);
        repeat (2) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_ready", 32'(in_ready),  32'(1));
        check("flush_valid", 32'(out_valid), 32'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("flush_quiet", 32'(out_valid), 32'(0));
        end
        accept(32'h0000_0100, 5'd1, 1'b0);
        wait_valid(lat);
        check("post_flush_y",   out_y,    32'h0000_0080);
        check("post_flush_lat", 32'(lat), 32'd2);
        drain();

        accept(32'hDEAD_BEEF, 5'd20, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_ready", 32'(in_ready),  32'(1));
        check("midrst_valid", 32'(out_valid), 32'(0));
        check("midrst_y",     out_y,          32'h0000_0000);

        // Randomized traffic: the compare process checks every cycle.
        repeat (4000) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_a      = $urandom;
            case ($urandom_range(0, 7))
                0:       in_shamt = 5'd0;
                1:       in_shamt = 5'd31;
                default: in_shamt = 5'($urandom);
            endcase
            in_arith  = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            rst_n     = ($urandom_range(0, 499) != 0);
            @(negedge clk);
        end
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (20) @(negedge clk);
        check("random_transfers", 32'(n_xfer > 100), 32'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
